pixel_fetch: RTL

PIXEL_FETCH -- requirements
Module: pixel_fetch

---
 rtl/pixel_fetch_pkg.sv | 6 +
 rtl/pixel_fetch_fifo.sv | 40 ++++
 rtl/pixel_fetch.sv | 82 ++++++++
 3 files changed

// File: rtl/pixel_fetch_pkg.sv
// pixel_fetch_pkg: shared FSM state type and constants for the pixel fetch master.
package pixel_fetch_pkg;
  typedef enum logic {IDLE, BUS} state_e;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam logic [3:0] SEL_ALL = 4'hF;
endpackage

// File: rtl/pixel_fetch_fifo.sv
// pixel_fetch_fifo: synchronous first-word-fall-through FIFO with occupancy count.
module pixel_fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [W-1:0]             wdata_i,
  input  logic                     pop_i,
  output logic [W-1:0]             rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign empty_o = cnt_q == '0;
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign do_pop = pop_i && !empty_o;
  // a pop frees the slot in the same cycle, so a push into a full FIFO is still taken
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rd_q];
  assign count_o = cnt_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk_i) if (do_push) mem_q[wr_q] <= wdata_i;
endmodule

// File: rtl/pixel_fetch.sv
// pixel_fetch: single-outstanding WISHBONE read master returning words through a FWFT FIFO.
// Define PIXEL_FETCH_STATS_EN to add read/stall statistics counters.
module pixel_fetch
  import pixel_fetch_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_adr_i,
  output logic        dat_valid_o,
  input  logic        dat_ready_i,
  output logic [31:0] dat_o,
  output logic [31:0] mwb_adr_o,
  output logic        mwb_stb_o,
  output logic        mwb_we_o,
  output logic [3:0]  mwb_sel_o,
  input  logic        mwb_ack_i,
  input  logic [31:0] mwb_dat_i
`ifdef PIXEL_FETCH_STATS_EN
  ,
  output logic [31:0] stat_reads_o,
  output logic [31:0] stat_stall_o
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  state_e state_q, state_d;
  logic [31:0] adr_q, adr_d;
  logic [CW-1:0] count;
  logic busy, ack, accept, fifo_empty, fifo_full;
  assign busy = state_q == BUS;
  assign ack = busy && mwb_ack_i;
  // the in-flight access owns a FIFO slot; same-cycle pops are not credited
  assign req_ready_o = !wb_rst_i && (!busy || mwb_ack_i) && !fifo_full &&
                       ({1'b0, count} + (CW+1)'(busy) < (CW+1)'(FIFO_DEPTH));
  assign accept = req_valid_i && req_ready_o;
  always_comb begin
    state_d = accept ? BUS : ack ? IDLE : state_q;
    adr_d = accept ? req_adr_i : adr_q;
  end
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      adr_q <= '0;
    end else begin
      state_q <= state_d;
      adr_q <= adr_d;
    end
  end
  assign mwb_stb_o = busy;
  assign mwb_adr_o = adr_q;
  assign mwb_we_o = 1'b0;
  assign mwb_sel_o = SEL_ALL;
  assign dat_valid_o = !fifo_empty;
  pixel_fetch_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_fifo (
    .clk_i(wb_clk_i),
    .rst_i(wb_rst_i),
    .push_i(ack),
    .wdata_i(mwb_dat_i),
    .pop_i(dat_ready_i),
    .rdata_o(dat_o),
    .count_o(count),
    .empty_o(fifo_empty),
    .full_o(fifo_full)
  );
`ifdef PIXEL_FETCH_STATS_EN
  logic [31:0] stat_reads_q, stat_stall_q;
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      stat_reads_q <= '0;
      stat_stall_q <= '0;
    end else begin
      if (ack) stat_reads_q <= stat_reads_q + 1'b1;
      if (busy && !mwb_ack_i) stat_stall_q <= stat_stall_q + 1'b1;
    end
  end
  assign stat_reads_o = stat_reads_q;
  assign stat_stall_o = stat_stall_q;
`endif
endmodule
